// File: rtl/step_ctrl_if.sv
`default_nettype none
// step_ctrl_if: button pulses, CPU status and breakpoint setup into the step
// controller, plus the clock-enable and display status coming back out.
interface step_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             step_pulse;
    logic             run_pulse;
    logic             halt;
    logic [15:0]      pc;
    logic             bp_en;
    logic [15:0]      bp_addr;
    logic             cpu_en;
    logic [1:0]       state;
    logic             bp_hit;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output step_pulse, run_pulse, halt, pc, bp_en, bp_addr,
        input  cpu_en, state, bp_hit, cycle_cnt
    );

    modport slave (
        input  step_pulse, run_pulse, halt, pc, bp_en, bp_addr,
        output cpu_en, state, bp_hit, cycle_cnt
    );
endinterface
`default_nettype wire

// File: rtl/step_ctrl.sv
`default_nettype none
// step_ctrl: debug execution controller producing the CPU clock-enable for
// single-step, divided free run, halt and break-before-execute.
module step_ctrl #(
    parameter int RUN_DIV = 1,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    step_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_STEP = 2'b01,
        S_RUN  = 2'b10,
        S_HALT = 2'b11
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(RUN_DIV - 1);

    state_t           state_q;
    logic [15:0]      div_q;
    logic             first_q;
    logic             cpu_en_q;
    logic             bp_hit_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             slot;
    logic             bp_break;

    assign slot     = (div_q == DIV_LAST);
    // The first slot after entering RUN always issues so a run can leave a breakpoint.
    assign bp_break = bus.bp_en && (bus.pc == bus.bp_addr) && !first_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            div_q    <= 16'd0;
            first_q  <= 1'b0;
            cpu_en_q <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            cpu_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.halt) begin
                        state_q <= S_HALT;
                    end else if (bus.run_pulse) begin
                        state_q  <= S_RUN;
                        div_q    <= 16'd0;
                        first_q  <= 1'b1;
                        bp_hit_q <= 1'b0;
                    end else if (bus.step_pulse) begin
                        state_q  <= S_STEP;
                        cpu_en_q <= 1'b1;
                        bp_hit_q <= 1'b0;
                    end
                end
                S_STEP: begin
                    state_q <= S_IDLE;
                end
                S_RUN: begin
                    if (bus.halt) begin
                        state_q <= S_HALT;
                    end else if (bus.run_pulse) begin
                        state_q <= S_IDLE;
                    end else begin
                        div_q <= slot ? 16'd0 : div_q + 16'd1;
                        if (slot) begin
                            first_q <= 1'b0;
                            if (bp_break) begin
                                bp_hit_q <= 1'b1;
                                state_q  <= S_IDLE;
                            end else begin
                                cpu_en_q <= 1'b1;
                            end
                        end
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cpu_en_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cpu_en    = cpu_en_q;
    assign bus.state     = state_q;
    assign bus.bp_hit    = bp_hit_q;
    assign bus.cycle_cnt = cnt_q;
endmodule
`default_nettype wire

// File: doc/step_ctrl.md
# step_ctrl

Execution controller for the 16-bit RISC processor's debug front end. Consumes the one-shot conditioned step and run button pulses, the CPU halt flag and a PC breakpoint, and produces the single clock-enable that advances the CPU datapath. Supports single-step, free/slow run, halt and break-before-execute. Maintains a saturating count of issued CPU cycles for the display.

## Interface
- RUN_DIV, 1: clk cycles per issued cpu_en in RUN; legal range 1..2^16-1.
- CNT_W, 16: width of cycle_cnt.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- step_pulse  in  1  one-cycle pulse from one-shot conditioner, step button.
- run_pulse  in  1  one-cycle pulse from one-shot conditioner, run/stop button.
- halt  in  1  level from CPU, high once HLT has executed.
- pc  in  16  current CPU program counter.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  16  breakpoint address.
- cpu_en  out  1  CPU clock-enable, registered.
- state  out  2  IDLE=00, STEP=01, RUN=10, HALTED=11.
- bp_hit  out  1  sticky breakpoint-taken flag.
- cycle_cnt  out  CNT_W  number of cpu_en cycles issued, saturating.

## Operation
- Reset: state=IDLE, cpu_en=0, bp_hit=0, cycle_cnt=0, divider=0, first-issue flag=0.
- IDLE:
  - halt=1 -> HALTED; this has the highest priority.
  - Otherwise, run_pulse -> RUN. run_pulse wins over a simultaneous step_pulse.
  - Otherwise, step_pulse -> STEP.
  - An accepted step_pulse or run_pulse clears bp_hit.
- STEP: lasts exactly one cycle with cpu_en=1, then -> IDLE. Pulses arriving in STEP are dropped. Breakpoint is not checked, so stepping off a breakpoint is always allowed.
- RUN:
  - Divider counts 0..RUN_DIV-1. It is cleared on RUN entry.
  - An issue slot occurs when the divider is RUN_DIV-1. With RUN_DIV=1, every cycle is an issue slot.
  - At an issue slot:
    - If bp_en=1 and pc==bp_addr and this is not the first issue slot since RUN entry: suppress cpu_en, set bp_hit, -> IDLE.
    - Else: assert cpu_en for that cycle.
  - run_pulse -> IDLE at any time; no cpu_en in that cycle.
  - halt=1 -> HALTED; this takes priority over run_pulse and over an issue slot.
  - step_pulse is ignored.
- HALTED: cpu_en=0. All pulses are ignored. Only reset exits.
- cycle_cnt increments on every cycle with cpu_en=1 and holds at 2^CNT_W-1.

## Timing
- cpu_en is a Moore output registered from state and divider. It rises the cycle after the accepting edge.
- Latency from step_pulse (sampled at edge N) to cpu_en: high during cycle N+1, low at N+2. Exactly one pulse per step.
- RUN entry at edge N: first cpu_en is RUN_DIV cycles later. Subsequent cpu_en pulses follow every RUN_DIV cycles.
- Breakpoint compare uses pc as sampled at the issue-slot edge, so it is a break before that instruction executes.
- halt is sampled every cycle. If halt rises during a cpu_en=1 cycle, cpu_en drops on the next cycle.
- Asynchronous reset mid-RUN forces all outputs to reset values immediately. No cpu_en glitch is permitted after reset deassertion.
- The divider is compared at full 16-bit width; it wraps to 0 after RUN_DIV-1.

## Test plan
- Reset, then step_pulse at cycle 5 -> cpu_en=1 only in cycle 6, cycle_cnt=1, state back to 00 at cycle 7.
- RUN_DIV=4: run_pulse, wait 20 cycles, run_pulse -> exactly 5 cpu_en pulses spaced 4 cycles apart, cycle_cnt=5, state=00.
- bp_en=1, bp_addr=0x0010. Run with pc incrementing per cpu_en from 0x000C -> break when pc=0x0010 with no cpu_en at that slot, bp_hit=1, cycle_cnt=4. Resume with run_pulse -> first slot issues at 0x0010 and bp_hit clears.
- In RUN, raise halt together with run_pulse -> state=11 next cycle, cpu_en=0 thereafter. Further step/run pulses have no effect.
- step_pulse and run_pulse in the same cycle from IDLE -> state=10 and no single-step pulse.
- CNT_W=4: issue 20 steps -> cycle_cnt saturates at 15. Assert reset low mid-RUN -> all outputs 0 at once and state=00.
